// File: rtl/bp_pkg.sv
// Shared predictor state encoding and direction helpers for the resolve tracker.
package bp_pkg;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } state_t;

  function automatic logic pred_dir(input state_t s);
    return s[1];
  endfunction

  function automatic logic is_strong(input state_t s);
    return (s == STRONG_NT) || (s == STRONG_T);
  endfunction

endpackage

// File: rtl/bp_res_ifc.sv
// Issue/resolve handshake bundle between a branch driver and the resolve tracker.
interface bp_res_ifc
  import bp_pkg::*;
(
  input logic clk
);

  logic   issue_valid;
  state_t prediction;
  logic   issue_ready;
  logic   resolve_valid;
  logic   resolve_taken;

  modport dut (input clk, issue_valid, prediction, resolve_valid, resolve_taken,
               output issue_ready);
  modport drv (input clk, issue_ready,
               output issue_valid, prediction, resolve_valid, resolve_taken);

endinterface

// File: rtl/bp_pred_fifo.sv
// In-order queue of issued predictions; occupancy drives full/empty.
module bp_pred_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic                         pop,
  input  state_t                       din,
  output state_t                       dout,
  output logic [$clog2(DEPTH+1)-1:0]   pending,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  state_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_pending;
  logic               w_push;
  logic               w_pop;

  assign full    = (r_pending == CNT_W'(DEPTH));
  assign empty   = (r_pending == '0);
  assign pending = r_pending;
  assign dout    = r_mem[r_rd_ptr];
  assign w_push  = push && !full;
  assign w_pop   = pop && !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_pending <= r_pending + CNT_W'(1);
      else if (w_pop && !w_push) r_pending <= r_pending - CNT_W'(1);
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/bp_resolve_tracker.sv
// Compares buffered predictions against resolved outcomes; pulses mispredicts
// and keeps saturating accuracy counters plus sticky protocol-error flags.
module bp_resolve_tracker
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       issue_valid,
  input  state_t                     prediction,
  output logic                       issue_ready,
  input  logic                       resolve_valid,
  input  logic                       resolve_taken,
  input  logic                       stats_clr,
  output logic                       mispredict,
  output logic                       mispredict_strong,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic [CNT_W-1:0]           total_cnt,
  output logic [CNT_W-1:0]           miss_cnt,
  output logic [CNT_W-1:0]           strong_miss_cnt,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  logic               w_full;
  logic               w_empty;
  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_mismatch;
  logic               w_strong_miss;
  state_t             w_head;

  logic               r_mispredict_p1;
  logic               r_mispredict_strong_p1;
  logic [CNT_W-1:0]   r_total_cnt;
  logic [CNT_W-1:0]   r_miss_cnt;
  logic [CNT_W-1:0]   r_strong_miss_cnt;
  logic               r_err_overflow;
  logic               r_err_underflow;

  assign w_ready       = reset_n && !w_full;
  assign w_push        = issue_valid && w_ready;
  assign w_pop         = resolve_valid && !w_empty;
  assign w_mismatch    = w_pop && (pred_dir(w_head) ^ resolve_taken);
  assign w_strong_miss = w_mismatch && is_strong(w_head);

  bp_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (prediction),
    .dout    (w_head),
    .pending (pending),
    .full    (w_full),
    .empty   (w_empty)
  );

  // Resolve stage -> registered pulses and statistics
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mispredict_p1        <= 1'b0;
      r_mispredict_strong_p1 <= 1'b0;
      r_total_cnt            <= '0;
      r_miss_cnt             <= '0;
      r_strong_miss_cnt      <= '0;
      r_err_overflow         <= 1'b0;
      r_err_underflow        <= 1'b0;
    end else begin
      r_mispredict_p1        <= w_mismatch;
      r_mispredict_strong_p1 <= w_strong_miss;
      if (stats_clr) begin
        r_total_cnt       <= '0;
        r_miss_cnt        <= '0;
        r_strong_miss_cnt <= '0;
        r_err_overflow    <= 1'b0;
        r_err_underflow   <= 1'b0;
      end else begin
        r_total_cnt       <= sat_inc(r_total_cnt, w_pop);
        r_miss_cnt        <= sat_inc(r_miss_cnt, w_mismatch);
        r_strong_miss_cnt <= sat_inc(r_strong_miss_cnt, w_strong_miss);
        r_err_overflow    <= r_err_overflow | (issue_valid && !w_ready);
        r_err_underflow   <= r_err_underflow | (resolve_valid && w_empty);
      end
    end
  end

  assign issue_ready       = w_ready;
  assign mispredict        = r_mispredict_p1;
  assign mispredict_strong = r_mispredict_strong_p1;
  assign total_cnt         = r_total_cnt;
  assign miss_cnt          = r_miss_cnt;
  assign strong_miss_cnt   = r_strong_miss_cnt;
  assign err_overflow      = r_err_overflow;
  assign err_underflow     = r_err_underflow;

endmodule
